// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle unsigned subtractor, diff = a - b - bin.
// Each RUN cycle subtracts one CHUNK-wide slice, LSB slice first, and carries
// a registered borrow into the next slice. N = Width/CHUNK cycles per op.
// Optional build macro: SUB_SAT_EN clamps diff to 0 when the final borrow is 1.
module chunked_subtractor #(
    parameter int unsigned Width = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] diff,
    output logic             bout
);

    localparam int unsigned N  = Width / CHUNK;
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operands shift right one slice per cycle, so the live slice is
    // always in the low CHUNK bits; the result fills in from the top.
    logic [Width-1:0] a_sh;
    logic [Width-1:0] b_sh;
    logic [Width-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt;

    logic [CHUNK:0]   chunk_sub_c;
    logic [Width-1:0] res_full_c;
    logic             last_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the single CHUNK-wide subtract stage
    always_comb begin
        state_next  = state;
        last_c      = (cnt == CW'(N - 1));
        chunk_sub_c = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
                      - (CHUNK+1)'(br_q);
        res_full_c  = (res_q >> CHUNK)
                      | (Width'(chunk_sub_c[CHUNK-1:0]) << (Width - CHUNK));
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, per-slice accumulation and final result load
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br_q  <= bin;
                        res_q <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    br_q  <= chunk_sub_c[CHUNK];
                    res_q <= res_full_c;
                    cnt   <= cnt + CW'(1);
                    if (last_c) begin
                        bout <= chunk_sub_c[CHUNK];
`ifdef SUB_SAT_EN
                        // Unsigned floor: a negative result clamps to zero.
                        diff <= chunk_sub_c[CHUNK] ? '0 : res_full_c;
`else
                        diff <= res_full_c;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake outputs, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed self-checking bench for chunked_subtractor
// with Width=32, CHUNK=8 (four slices per op).
module tb_chunked_subtractor;

    localparam int unsigned W = 32;
    localparam int unsigned C = 8;
    localparam int N_OPS = 4;
`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks   = 0;
    int failures = 0;

    chunked_subtractor #(.Width(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for done; lat = edges after acceptance, -1 on timeout.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic binv, output int lat);
        a = av; b = bv; bin = binv; start = 1'b1;
        tick();
        start = 1'b0;
        a = '1; b = '1; bin = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (diff !== 32'h0) begin failures++; $display("FAIL reset_diff got %h want 0", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got %0b want 0", bout); end
    endtask

    task automatic test_basic();
        int lat;
        a = 32'd5; b = 32'd3; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_run got %0b want 1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early got %0b want 0", done); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        checks++; if (lat !== N_OPS) begin failures++; $display("FAIL basic_latency got %0d want %0d", lat, N_OPS); end
        checks++; if (diff !== 32'd2) begin failures++; $display("FAIL basic_diff got %h want 2", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL basic_bout got %0b want 0", bout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got %0b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %0b want 0", done); end
        checks++; if (diff !== 32'd2) begin failures++; $display("FAIL basic_diff_hold got %h want 2", diff); end
    endtask

    // Table of operand patterns covering borrow propagation and underflow.
    task automatic test_vectors();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic         vi [5];
        logic [W-1:0] vd [5];
        logic         vo [5];
        int lat;
        va[0] = 32'h0100_0000; vb[0] = 32'h1;  vi[0] = 1'b0; vd[0] = 32'h00FF_FFFF; vo[0] = 1'b0;
        va[1] = 32'h0;         vb[1] = 32'h1;  vi[1] = 1'b0; vd[1] = 32'hFFFF_FFFF; vo[1] = 1'b1;
        va[2] = 32'h10;        vb[2] = 32'h10; vi[2] = 1'b1; vd[2] = 32'hFFFF_FFFF; vo[2] = 1'b1;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0;  vi[3] = 1'b1; vd[3] = 32'hFFFF_FFFE; vo[3] = 1'b0;
        va[4] = 32'h8000_0000; vb[4] = 32'h1234_5678; vi[4] = 1'b0; vd[4] = 32'h6DCB_A988; vo[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [W-1:0] exp_d;
            exp_d = (SAT && vo[k]) ? 32'h0 : vd[k];
            run_op(va[k], vb[k], vi[k], lat);
            checks++; if (lat !== N_OPS) begin failures++; $display("FAIL vec%0d_latency got %0d want %0d", k, lat, N_OPS); end
            checks++; if (diff !== exp_d) begin failures++; $display("FAIL vec%0d_diff got %h want %h", k, diff, exp_d); end
            checks++; if (bout !== vo[k]) begin failures++; $display("FAIL vec%0d_bout got %0b want %0b", k, bout, vo[k]); end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        a = 32'd9; b = 32'd4; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL ignored_pulses got %0d want 1", pulses); end
        checks++; if (diff !== 32'd5) begin failures++; $display("FAIL ignored_diff got %h want 5", diff); end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        int lat;
        a = 32'hDEAD_BEEF; b = 32'h1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got %0b want 0", done); end
        checks++; if (diff !== 32'h0) begin failures++; $display("FAIL abort_diff got %h want 0", diff); end
        checks++; if (bout !== 1'b0) begin failures++; $display("FAIL abort_bout got %0b want 0", bout); end
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        run_op(32'd7, 32'd2, 1'b0, lat);
        checks++; if (lat !== N_OPS) begin failures++; $display("FAIL after_abort_latency got %0d want %0d", lat, N_OPS); end
        checks++; if (diff !== 32'd5) begin failures++; $display("FAIL after_abort_diff got %h want 5", diff); end
        tick();
    endtask

    // start held high: ops repeat once every N+2 cycles.
    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        start = 1'b0;
        checks++; if (first !== N_OPS) begin failures++; $display("FAIL b2b_first got %0d want %0d", first, N_OPS); end
        checks++; if (second - first !== N_OPS + 2) begin failures++; $display("FAIL b2b_period got %0d want %0d", second - first, N_OPS + 2); end
        checks++; if (diff !== 32'd99) begin failures++; $display("FAIL b2b_diff got %h want 99", diff); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
